// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: host request/response and RAM-side bus of mem_ctrl; master = host+RAM model, slave = controller
interface mem_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_read;
    logic        mem_write;
    modport master (
        output req, we, addr, wdata, mem_dout,
        input  rdata, busy, done, err, mem_addr, mem_din, mem_read, mem_write
    );
    modport slave (
        input  req, we, addr, wdata, mem_dout,
        output rdata, busy, done, err, mem_addr, mem_din, mem_read, mem_write
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: IDLE/SETUP/ACCESS/DONE single-access RAM controller (clk, sync active-high clr, bus: req/we/addr/wdata -> rdata/busy/done/err, mem_addr/mem_din/mem_read/mem_write <- mem_dout); MEM_CTRL_BOUNDS_CHECK_EN enables out-of-range rejection
module mem_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 9
) (
    input logic clk,
    input logic clr,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t      state, state_nx;
    logic        we_r;
    logic        err_r;
    logic        oor;
    logic        last;
    logic [3:0]  cnt;
    logic [31:0] rdata_r;
    logic [31:0] addr_r;
    logic [31:0] din_r;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
    assign oor = |bus.addr[31:ADDR_BITS];
`else
    assign oor = 1'b0;
`endif
    assign last = cnt == 4'(WAIT_CYCLES - 1);
    always_comb begin
        state_nx = state == IDLE   ? (bus.req ? SETUP : IDLE)
                 : state == SETUP  ? (err_r ? DONE : ACCESS)
                 : state == ACCESS ? (last ? DONE : ACCESS)
                 : IDLE;
    end
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            cnt     <= 4'd0;
            rdata_r <= 32'd0;
            addr_r  <= 32'd0;
            din_r   <= 32'd0;
        end else begin
            if (state == IDLE && bus.req) begin
                we_r  <= bus.we;
                err_r <= oor;
                if (!oor) begin
                    addr_r <= {{(32-ADDR_BITS){1'b0}}, bus.addr[ADDR_BITS-1:0]};
                    din_r  <= bus.wdata;
                end
            end
            cnt <= state == ACCESS ? cnt + 4'd1 : 4'd0;
            if (state == ACCESS && last && !we_r) rdata_r <= bus.mem_dout;
        end
    end
    assign bus.rdata     = rdata_r;
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign bus.err       = err_r && state == DONE;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_din   = din_r;
    assign bus.mem_read  = state == ACCESS && !we_r;
    assign bus.mem_write = state == ACCESS && we_r;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized transaction-level check of mem_ctrl against a word-array reference model
module tb_mem_ctrl;
    localparam int W = 2;
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif
    logic clk = 1'b0;
    logic clr;
    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] ram   [512];
    logic [31:0] model [512];
    logic [31:0] exp_rd = 32'd0;
    mem_ctrl_if b();
    mem_ctrl #(.WAIT_CYCLES(W), .ADDR_BITS(9)) dut (.clk(clk), .clr(clr), .bus(b.slave));
    always #5 clk = ~clk;
    always @(posedge clk) if (b.mem_write) ram[b.mem_addr[8:0]] <= b.mem_din;
    assign b.mem_dout = ram[b.mem_addr[8:0]];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input bit poke);
        int lat, wc, rc, bad_addr, ov, idx;
        bit oor;
        logic [31:0] ea;
        oor = BC && a >= 32'd512;
        idx = int'(a[8:0]);
        ea = {23'd0, a[8:0]};
        lat = 0; wc = 0; rc = 0; bad_addr = 0; ov = 0;
        b.req = 1'b1; b.we = w; b.addr = a; b.wdata = d;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                b.req = 1'b0;
                chk("busy_on", 32'(b.busy), 32'd1);
            end
            if (poke && k == 3) begin b.req = 1'b1; b.we = 1'b1; b.addr = 32'h26; end
            if (poke && k == 4) b.req = 1'b0;
            wc += int'(b.mem_write);
            rc += int'(b.mem_read);
            if ((b.mem_read || b.mem_write) && b.mem_addr !== ea) bad_addr++;
            if (poke && b.mem_addr === 32'h26) bad_addr++;
            if (b.mem_read && b.mem_write) ov++;
            if (b.done) begin lat = k; break; end
        end
        if (!oor) begin
            if (w) model[idx] = d;
            else   exp_rd = model[idx];
        end
        chk("latency", 32'(lat), oor ? 32'd2 : 32'(W + 2));
        chk("err", 32'(b.err), 32'(oor));
        chk("rdata", b.rdata, exp_rd);
        chk("wr_cycles", 32'(wc), (!oor && w) ? 32'(W) : 32'd0);
        chk("rd_cycles", 32'(rc), (!oor && !w) ? 32'(W) : 32'd0);
        chk("strobe_addr", 32'(bad_addr), 32'd0);
        chk("overlap", 32'(ov), 32'd0);
        if (!oor) chk("addr_hold", b.mem_addr, ea);
        @(negedge clk);
        chk("done_pulse", 32'(b.done), 32'd0);
        chk("idle", 32'(b.busy), 32'd0);
    endtask
    task automatic abort_read(input logic [31:0] a);
        int dn;
        b.req = 1'b1; b.we = 1'b0; b.addr = a;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) b.req = 1'b0;
        end
        chk("abort_in_access", 32'(b.mem_read), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_rd = 32'd0;
        chk("abort_busy", 32'(b.busy), 32'd0);
        chk("abort_strobes", {30'd0, b.mem_read, b.mem_write}, 32'd0);
        chk("abort_rdata", b.rdata, 32'd0);
        chk("abort_addr", b.mem_addr, 32'd0);
        dn = int'(b.done);
        repeat (6) begin
            @(negedge clk);
            dn += int'(b.done);
        end
        chk("abort_no_done", 32'(dn), 32'd0);
    endtask
    task automatic back_to_back(input logic [31:0] a1, input logic [31:0] a2);
        int d1, d2, ov;
        d1 = -1; d2 = -1; ov = 0;
        b.req = 1'b1; b.we = 1'b0; b.addr = a1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) b.addr = a2;
            if (d1 > 0 && c == d1 + 2) b.req = 1'b0;
            if (b.mem_read && b.mem_write) ov++;
            if (b.done) begin
                if (d1 < 0) begin
                    d1 = c;
                    chk("b2b_rdata1", b.rdata, model[a1[8:0]]);
                end else begin
                    d2 = c;
                    chk("b2b_rdata2", b.rdata, model[a2[8:0]]);
                    break;
                end
            end
        end
        b.req = 1'b0;
        exp_rd = model[a2[8:0]];
        chk("b2b_gap", 32'(d2 - d1), 32'(W + 3));
        chk("b2b_overlap", 32'(ov), 32'd0);
        @(negedge clk);
    endtask
    initial begin
        logic [31:0] a;
        for (int i = 0; i < 512; i++) begin
            ram[i] = $urandom;
            model[i] = ram[i];
        end
        clr = 1'b1;
        b.req = 1'b0; b.we = 1'b0; b.addr = 32'd0; b.wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_done_err", {30'd0, b.done, b.err}, 32'd0);
        chk("rst_rdata", b.rdata, 32'd0);
        chk("rst_mem_addr", b.mem_addr, 32'd0);
        chk("rst_mem_din", b.mem_din, 32'd0);
        chk("rst_strobes", {30'd0, b.mem_read, b.mem_write}, 32'd0);
        xact(1'b1, 32'h5F, 32'hDEADBEEF, 1'b0);
        xact(1'b0, 32'h5F, 32'd0, 1'b0);
        chk("readback", b.rdata, 32'hDEADBEEF);
        xact(1'b0, 32'h5F, 32'd0, 1'b1);
        abort_read(32'h13);
        xact(1'b0, 32'h200, 32'd0, 1'b0);
        xact(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        xact(1'b0, 32'h1FF, 32'd0, 1'b0);
        back_to_back(32'h5F, 32'h1FF);
        repeat (40) begin
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 511));
            xact(1'($urandom_range(0, 1)), a, 32'($urandom), 1'($urandom_range(0, 1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
